// File: rtl/button_conditioner_pkg.sv
// Shared types and button indices for the button conditioner.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_LEFT  = 3;
  localparam int NUM_BTN   = 4;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button levels in, conditioned move pulses and held levels out.
interface button_conditioner_if;
  logic       btn_up_raw;
  logic       btn_down_raw;
  logic       btn_right_raw;
  logic       btn_left_raw;
  logic       Up;
  logic       Down;
  logic       Right;
  logic       Left;
  logic [3:0] btn_held;

  modport master (
    output btn_up_raw, btn_down_raw, btn_right_raw, btn_left_raw,
    input  Up, Down, Right, Left, btn_held
  );

  modport slave (
    input  btn_up_raw, btn_down_raw, btn_right_raw, btn_left_raw,
    output Up, Down, Right, Left, btn_held
  );
endinterface

// File: rtl/button_conditioner_channel.sv
// One button: 2-flop synchronizer, stable-interval debounce FSM, press one-shot.
module debounce_channel
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_pulse,
  output logic o_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1, r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_chan_p;
  btn_state_t       r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_cnt    <= '0;
      r_chan_p <= 1'b0;
      r_state  <= IDLE;
    end else begin
      r_sync1  <= i_raw;
      r_sync2  <= r_sync1;
      r_chan_p <= 1'b0;
      // Any disagreement during a wait restarts the whole interval.
      case (r_state)
        IDLE: if (r_sync2) begin
          r_state <= PRESS_WAIT;
          r_cnt   <= '0;
        end
        PRESS_WAIT: begin
          if (!r_sync2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state  <= PRESSED;
            r_chan_p <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: if (!r_sync2) begin
          r_state <= RELEASE_WAIT;
          r_cnt   <= '0;
        end
        RELEASE_WAIT: begin
          if (r_sync2) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_pulse = r_chan_p;
  assign o_level = (r_state == PRESSED) || (r_state == RELEASE_WAIT);

endmodule

// File: rtl/button_conditioner.sv
// Four debounced button channels with opposing-direction pulse cancellation.
module button_conditioner
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);

  logic [NUM_BTN-1:0] w_raw, w_p, w_level;
  logic               r_up, r_down, r_right, r_left;
  logic [NUM_BTN-1:0] r_held;

  assign w_raw[BTN_UP]    = bus.btn_up_raw;
  assign w_raw[BTN_DOWN]  = bus.btn_down_raw;
  assign w_raw[BTN_RIGHT] = bus.btn_right_raw;
  assign w_raw[BTN_LEFT]  = bus.btn_left_raw;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (w_raw[g]),
      .o_pulse (w_p[g]),
      .o_level (w_level[g])
    );
  end

  // Coincident opposing pulses cancel so downstream never sees a contradictory move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_right <= 1'b0;
      r_left  <= 1'b0;
      r_held  <= '0;
    end else begin
      r_up    <= w_p[BTN_UP]    & ~w_p[BTN_DOWN];
      r_down  <= w_p[BTN_DOWN]  & ~w_p[BTN_UP];
      r_right <= w_p[BTN_RIGHT] & ~w_p[BTN_LEFT];
      r_left  <= w_p[BTN_LEFT]  & ~w_p[BTN_RIGHT];
      r_held  <= w_level;
    end
  end

  assign bus.Up       = r_up;
  assign bus.Down     = r_down;
  assign bus.Right    = r_right;
  assign bus.Left     = r_left;
  assign bus.btn_held = r_held;

endmodule

// File: tb/tb_button_conditioner.sv
// Scenario and randomized checks of button_conditioner against a run-length debounce model.
module tb_button_conditioner;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw = 4'h0;   // {left, right, down, up}
  int         total = 0;
  int         bad = 0;

  button_conditioner_if bif();
  assign bif.btn_up_raw    = raw[0];
  assign bif.btn_down_raw  = raw[1];
  assign bif.btn_right_raw = raw[2];
  assign bif.btn_left_raw  = raw[3];

  button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  wire [3:0] dmv   = {bif.Left, bif.Right, bif.Down, bif.Up};
  wire [3:0] dheld = bif.btn_held;

  // Model: a button's accepted level flips once the synchronized input has
  // disagreed with it for D+1 consecutive samples; a 0->1 flip is a press.
  logic [3:0] md0, md1, mlvl, mp, mmv, mheld;
  int         mrun [4];

  always @(posedge clk or negedge rst_n) begin : mdl
    logic [3:0] nl, np;
    int         nr [4];
    if (!rst_n) begin
      md0 <= '0; md1 <= '0; mlvl <= '0; mp <= '0; mmv <= '0; mheld <= '0;
      for (int i = 0; i < 4; i++) mrun[i] <= 0;
    end else begin
      mmv   <= {mp[3] & ~mp[2], mp[2] & ~mp[3], mp[1] & ~mp[0], mp[0] & ~mp[1]};
      mheld <= mlvl;
      nl = mlvl;
      np = '0;
      for (int i = 0; i < 4; i++) begin
        if (md1[i] != mlvl[i]) begin
          nr[i] = mrun[i] + 1;
          if (nr[i] == D + 1) begin
            nl[i] = md1[i];
            np[i] = md1[i];
            nr[i] = 0;
          end
        end else begin
          nr[i] = 0;
        end
      end
      mlvl <= nl;
      mp   <= np;
      for (int i = 0; i < 4; i++) mrun[i] <= nr[i];
      md1 <= md0;
      md0 <= raw;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    raw = 4'h0;
    repeat (3 * D + 10) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw   = 4'hF;
    repeat (3) step();
    total++;
    if (dmv !== 4'h0 || dheld !== 4'h0) begin
      bad++;
      $display("FAIL reset_hold mv=%b held=%b want 0000/0000", dmv, dheld);
    end
    raw   = 4'b0001;
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      total++;
      if (dmv !== ((k == 7) ? 4'b0001 : 4'b0000) || dheld[0] !== (k >= 7)) begin
        bad++;
        $display("FAIL reset_release k=%0d mv=%b held0=%b want up=%0d held0=%0d",
                 k, dmv, dheld[0], (k == 7), (k >= 7));
      end
      total++;
      if ({dmv, dheld} !== {mmv, mheld}) begin
        bad++;
        $display("FAIL reset_model k=%0d dut=%b model=%b", k, {dmv, dheld}, {mmv, mheld});
      end
    end
    settle();
  endtask

  task automatic test_clean_press();
    raw = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if (dmv !== ((k == 7) ? 4'b0001 : 4'b0000) || dheld !== ((k >= 7) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL clean_press k=%0d mv=%b held=%b", k, dmv, dheld);
      end
    end
    raw = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      step();
      total++;
      if (dmv !== 4'b0000 || dheld[0] !== (k < 7)) begin
        bad++;
        $display("FAIL clean_release k=%0d mv=%b held0=%b want held0=%0d", k, dmv, dheld[0], (k < 7));
      end
    end
    settle();
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 20; k++) begin
      raw[2] = (k < 4) ? ~k[0] : 1'b1;
      step();
      total++;
      if (dmv !== ((k == 11) ? 4'b0100 : 4'b0000)) begin
        bad++;
        $display("FAIL bounce k=%0d mv=%b want right=%0d", k, dmv, (k == 11));
      end
    end
    settle();
    for (int k = 0; k < 15; k++) begin
      raw[2] = (k < 3);
      step();
      total++;
      if (dmv !== 4'b0000 || dheld !== 4'b0000) begin
        bad++;
        $display("FAIL glitch k=%0d mv=%b held=%b want 0000/0000", k, dmv, dheld);
      end
    end
    settle();
  endtask

  task automatic test_opposing();
    raw = 4'b0011;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if (dmv !== 4'b0000 || dheld !== ((k >= 7) ? 4'b0011 : 4'b0000)) begin
        bad++;
        $display("FAIL opposing k=%0d mv=%b held=%b", k, dmv, dheld);
      end
    end
    settle();
  endtask

  task automatic test_orthogonal();
    raw = 4'b0101;
    for (int k = 0; k < 15; k++) begin
      step();
      total++;
      if (dmv !== ((k == 7) ? 4'b0101 : 4'b0000)) begin
        bad++;
        $display("FAIL orthogonal k=%0d mv=%b want=%b", k, dmv, (k == 7) ? 4'b0101 : 4'b0000);
      end
    end
    settle();
  endtask

  task automatic test_reset_midcount();
    raw = 4'b0001;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dmv !== 4'h0 || dheld !== 4'h0) begin
      bad++;
      $display("FAIL midreset_async mv=%b held=%b want 0000/0000", dmv, dheld);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (dmv !== 4'h0 || dheld !== 4'h0) begin
        bad++;
        $display("FAIL midreset_hold k=%0d mv=%b held=%b", k, dmv, dheld);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step();
      total++;
      if (dmv !== ((k == 7) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL midreset_release k=%0d mv=%b want up=%0d", k, dmv, (k == 7));
      end
    end
    settle();
  endtask

  task automatic test_random();
    int hold [4];
    int pulses;
    pulses = 0;
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          raw[i]  = $urandom_range(0, 1);
          hold[i] = $urandom_range(1, 2 * D + 4);
        end else begin
          hold[i]--;
        end
      end
      step();
      pulses += $countones(dmv);
      total++;
      if ({dmv, dheld} !== {mmv, mheld}) begin
        bad++;
        $display("FAIL random c=%0d raw=%b dut=%b model=%b", c, raw, {dmv, dheld}, {mmv, mheld});
      end
    end
    total++;
    if (pulses == 0) begin
      bad++;
      $display("FAIL random_activity pulses=%0d want >0", pulses);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_opposing();
    test_orthogonal();
    test_reset_midcount();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
